// File: rtl/keychain_pkg.sv
// Shared types and constants for the result framing path toward the host.
package keychain_pkg;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_HI, WAIT_LO, DONE} frame_tx_state_t;

  localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/result_frame_tx_if.sv
// Word hand-off channel into result_frame_tx (valid/ready, word accepted when both high).
interface result_frame_tx_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] word_in;
  logic             word_valid_in;
  logic             word_ready_out;

  modport master (output word_in, output word_valid_in, input word_ready_out);
  modport slave  (input word_in, input word_valid_in, output word_ready_out);
endinterface

// File: rtl/result_frame_tx.sv
// Frames one result word as SOF, data bytes MSB first, XOR checksum, and feeds
// the bytes to uart_transmit through its trigger/busy handshake.
module result_frame_tx
  import keychain_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter logic [7:0]  SOF_BYTE    = SOF_BYTE_DEFAULT,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  result_frame_tx_if.slave   word_if,
  output logic [7:0]         tx_byte_out,
  output logic               tx_trigger_out,
  input  logic               tx_busy_in,
  output logic               busy_out,
  output logic               frame_done_out,
  output logic               err_out
);

  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned IW     = $clog2(NBYTES + 2);
  localparam int unsigned TW     = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned DEPTH  = 1 << IW;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES + 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(ACK_TIMEOUT);

  frame_tx_state_t  state;
  logic [WIDTH-1:0] shreg;
  logic [IW-1:0]    idx;
  logic [7:0]       csum;
  logic [TW-1:0]    tmo;
  logic             ready_q;
  logic [7:0]       frame_bytes [DEPTH];
  logic [7:0]       cur_byte;
  logic             is_data;

  assign word_if.word_ready_out = ready_q;

  // Frame laid out as a table indexed directly by idx: SOF, data MSB first, checksum.
  assign frame_bytes[0]        = SOF_BYTE;
  assign frame_bytes[NBYTES+1] = csum;
  for (genvar g = 0; g < NBYTES; g++) begin : g_data
    assign frame_bytes[g+1] = shreg[WIDTH-8*g-1 -: 8];
  end
  for (genvar g = NBYTES + 2; g < DEPTH; g++) begin : g_pad
    assign frame_bytes[g] = '0;
  end

  always_comb begin
    cur_byte = frame_bytes[idx];
    is_data  = (idx != '0) && (idx != LAST_IDX);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= IDLE;
      shreg          <= '0;
      idx            <= '0;
      csum           <= '0;
      tmo            <= '0;
      ready_q        <= 1'b1;
      tx_byte_out    <= '0;
      tx_trigger_out <= 1'b0;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
      err_out        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          frame_done_out <= 1'b0;
          if (word_if.word_valid_in && ready_q) begin
            shreg    <= word_if.word_in;
            idx      <= '0;
            csum     <= '0;
            busy_out <= 1'b1;
            err_out  <= 1'b0;
            ready_q  <= 1'b0;
            state    <= SEND;
          end else begin
            ready_q  <= 1'b1;
          end
        end
        SEND: begin
          if (!tx_busy_in) begin
            tx_byte_out    <= cur_byte;
            tx_trigger_out <= 1'b1;
            tmo            <= '0;
            if (is_data) csum <= csum ^ cur_byte;
            state          <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          tx_trigger_out <= 1'b0;
          if (tx_busy_in) begin
            state <= WAIT_LO;
          end else if (tmo == TMO_MAX) begin
            // No acknowledge from the UART: flag it and carry on with the frame.
            err_out <= 1'b1;
            state   <= WAIT_LO;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!tx_busy_in) begin
            if (idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= SEND;
            end
          end
        end
        DONE: begin
          frame_done_out <= 1'b1;
          busy_out       <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_frame_tx.sv
// Bench for result_frame_tx at WIDTH=16 and WIDTH=32 against a behavioural UART
// stand-in that logs every triggered byte and holds busy for a set number of cycles.
module tb_result_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  result_frame_tx_if #(.WIDTH(16)) if16 ();
  result_frame_tx_if #(.WIDTH(32)) if32 ();

  logic [7:0] b16, b32;
  logic       t16, t32, busy16, busy32, bo16, bo32, fd16, fd32, e16, e32;
  logic       force16 = 1'b0, en16 = 1'b1, en32 = 1'b1;
  int         len16 = 20, len32 = 20;
  int         cnt16 = 0, cnt32 = 0, trig16 = 0, trig32 = 0, done16 = 0, done32 = 0;
  logic [7:0] log16[$];
  logic [7:0] log32[$];
  logic [7:0] exp_q[$];

  result_frame_tx #(.WIDTH(16), .SOF_BYTE(8'hA5), .ACK_TIMEOUT(16)) dut16 (
    .clk_in(clk), .rst_in(rst_n), .word_if(if16.slave), .tx_byte_out(b16),
    .tx_trigger_out(t16), .tx_busy_in(busy16), .busy_out(bo16),
    .frame_done_out(fd16), .err_out(e16));

  result_frame_tx #(.WIDTH(32), .SOF_BYTE(8'hA5), .ACK_TIMEOUT(16)) dut32 (
    .clk_in(clk), .rst_in(rst_n), .word_if(if32.slave), .tx_byte_out(b32),
    .tx_trigger_out(t32), .tx_busy_in(busy32), .busy_out(bo32),
    .frame_done_out(fd32), .err_out(e32));

  // UART stand-ins: latch the byte on trigger, then report busy for lenNN cycles.
  always @(posedge clk) begin
    if (t16) begin
      cnt16 <= len16;
      log16.push_back(b16);
      trig16 <= trig16 + 1;
    end else if (cnt16 != 0) cnt16 <= cnt16 - 1;
    if (fd16) done16 <= done16 + 1;
  end
  assign busy16 = force16 | (en16 && cnt16 != 0);

  always @(posedge clk) begin
    if (t32) begin
      cnt32 <= len32;
      log32.push_back(b32);
      trig32 <= trig32 + 1;
    end else if (cnt32 != 0) cnt32 <= cnt32 - 1;
    if (fd32) done32 <= done32 + 1;
  end
  assign busy32 = en32 && cnt32 != 0;

  // Reference frame: SOF, bytes MSB first, XOR of data bytes.
  task automatic make_expect(input logic [31:0] w, input int nb);
    logic [7:0] cs, b;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    cs = 8'h00;
    for (int i = 0; i < nb; i++) begin
      b = 8'((w >> (8 * (nb - 1 - i))) & 32'hFF);
      exp_q.push_back(b);
      cs = cs ^ b;
    end
    exp_q.push_back(cs);
  endtask

  task automatic send16(input logic [15:0] w, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    if16.word_in = w;
    if16.word_valid_in = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (if16.word_ready_out) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    if16.word_valid_in = 1'b0;
  endtask

  task automatic send32(input logic [31:0] w, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    if32.word_in = w;
    if32.word_valid_in = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (if32.word_ready_out) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    if32.word_valid_in = 1'b0;
  endtask

  task automatic wait_done16(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (done16 > base) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done32(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (done32 > base) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if16.word_valid_in = 1'b0; if16.word_in = '0;
    if32.word_valid_in = 1'b0; if32.word_in = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({if16.word_ready_out, b16, t16, bo16, fd16, e16} !== {1'b1, 8'h00, 4'b0000}) begin
      n_err++;
      $display("FAIL reset16: got %b want %b", {if16.word_ready_out, b16, t16, bo16, fd16, e16}, {1'b1, 8'h00, 4'b0000});
    end
    n_vec++;
    if ({if32.word_ready_out, b32, t32, bo32, fd32, e32} !== {1'b1, 8'h00, 4'b0000}) begin
      n_err++;
      $display("FAIL reset32: got %b want %b", {if32.word_ready_out, b32, t32, bo32, fd32, e32}, {1'b1, 8'h00, 4'b0000});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok; int bl, bt, bd; logic [7:0] got;
    len16 = 20; bl = log16.size(); bt = trig16; bd = done16;
    send16(16'h1234, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL basic_accept: ready never seen"); end
    wait_done16(bd, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL basic_done: no frame_done_out within budget"); end
    make_expect(32'h1234, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (bl + i < log16.size()) ? log16[bl + i] : 8'hxx;
      n_vec++;
      if (got !== exp_q[i]) begin n_err++; $display("FAIL basic_byte%0d: got %h want %h", i, got, exp_q[i]); end
    end
    repeat (5) @(negedge clk);
    n_vec++;
    if (trig16 - bt !== 4) begin n_err++; $display("FAIL basic_trigs: got %0d want 4", trig16 - bt); end
    n_vec++;
    if (done16 - bd !== 1) begin n_err++; $display("FAIL basic_done_pulses: got %0d want 1", done16 - bd); end
    n_vec++;
    if ({e16, bo16, if16.word_ready_out} !== 3'b001) begin
      n_err++; $display("FAIL basic_idle_flags: got %b want 001", {e16, bo16, if16.word_ready_out});
    end
  endtask

  task automatic test_wide();
    bit ok; int bl, bt, bd; logic [7:0] got;
    len32 = 15; bl = log32.size(); bt = trig32; bd = done32;
    send32(32'hDEADBEEF, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL wide_accept: ready never seen"); end
    wait_done32(bd, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL wide_done: no frame_done_out within budget"); end
    make_expect(32'hDEADBEEF, 4);
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (bl + i < log32.size()) ? log32[bl + i] : 8'hxx;
      n_vec++;
      if (got !== exp_q[i]) begin n_err++; $display("FAIL wide_byte%0d: got %h want %h", i, got, exp_q[i]); end
    end
    n_vec++;
    if (trig32 - bt !== 6) begin n_err++; $display("FAIL wide_trigs: got %0d want 6", trig32 - bt); end
  endtask

  task automatic test_back_to_back();
    bit ok; int bl, bt, bd, d_at, overlap; logic [7:0] got;
    len16 = 12; bl = log16.size(); bt = trig16; bd = done16; overlap = 0; d_at = -1;
    @(negedge clk);
    if16.word_in = 16'h0001; if16.word_valid_in = 1'b1;
    for (int i = 0; i < 100 && !if16.word_ready_out; i++) @(negedge clk);
    @(negedge clk);
    if16.word_in = 16'h00FF;
    for (int i = 0; i < 6000; i++) begin
      if (if16.word_ready_out && bo16) overlap++;
      if (if16.word_ready_out) begin d_at = done16 - bd; break; end
      @(negedge clk);
    end
    @(negedge clk);
    if16.word_valid_in = 1'b0;
    wait_done16(bd + 1, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_done: second frame incomplete"); end
    n_vec++;
    if (d_at !== 1) begin n_err++; $display("FAIL b2b_order: frames done at 2nd acceptance %0d want 1", d_at); end
    n_vec++;
    if (overlap !== 0) begin n_err++; $display("FAIL b2b_ready_busy: ready with busy %0d times want 0", overlap); end
    make_expect(32'h0001, 2);
    make_expect_append(32'h00FF);
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (bl + i < log16.size()) ? log16[bl + i] : 8'hxx;
      n_vec++;
      if (got !== exp_q[i]) begin n_err++; $display("FAIL b2b_byte%0d: got %h want %h", i, got, exp_q[i]); end
    end
    n_vec++;
    if (trig16 - bt !== 8) begin n_err++; $display("FAIL b2b_trigs: got %0d want 8", trig16 - bt); end
  endtask

  task automatic make_expect_append(input logic [15:0] w);
    exp_q.push_back(8'hA5);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8] ^ w[7:0]);
  endtask

  task automatic test_stall();
    bit ok; int bl, bt, bd; logic [7:0] got; logic [15:0] w;
    w = 16'($urandom); len16 = 10; bl = log16.size(); bt = trig16; bd = done16;
    @(negedge clk);
    force16 = 1'b1;
    send16(w, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL stall_accept: ready never seen"); end
    repeat (48) @(negedge clk);
    n_vec++;
    if ((trig16 - bt) !== 0 || t16 !== 1'b0) begin
      n_err++; $display("FAIL stall_hold: got %0d triggers want 0", trig16 - bt);
    end
    force16 = 1'b0;
    @(negedge clk);
    n_vec++;
    if (t16 !== 1'b1 || b16 !== 8'hA5) begin
      n_err++; $display("FAIL stall_release: trigger %b byte %h want 1 a5", t16, b16);
    end
    wait_done16(bd, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL stall_done: frame incomplete"); end
    make_expect({16'h0, w}, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (bl + i < log16.size()) ? log16[bl + i] : 8'hxx;
      n_vec++;
      if (got !== exp_q[i]) begin n_err++; $display("FAIL stall_byte%0d: got %h want %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_timeout();
    bit ok; int bl, bt, bd; logic [7:0] got;
    en16 = 1'b0; bl = log16.size(); bt = trig16; bd = done16;
    send16(16'hABCD, ok);
    for (int i = 0; i < 20 && t16 !== 1'b1; i++) @(negedge clk);
    repeat (14) @(negedge clk);
    n_vec++;
    if (e16 !== 1'b0) begin n_err++; $display("FAIL timeout_early: err %b want 0", e16); end
    repeat (6) @(negedge clk);
    n_vec++;
    if (e16 !== 1'b1) begin n_err++; $display("FAIL timeout_flag: err %b want 1", e16); end
    wait_done16(bd, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL timeout_done: frame incomplete"); end
    n_vec++;
    if (trig16 - bt !== 4) begin n_err++; $display("FAIL timeout_trigs: got %0d want 4", trig16 - bt); end
    n_vec++;
    if (e16 !== 1'b1) begin n_err++; $display("FAIL timeout_sticky: err %b want 1", e16); end
    make_expect(32'hABCD, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (bl + i < log16.size()) ? log16[bl + i] : 8'hxx;
      n_vec++;
      if (got !== exp_q[i]) begin n_err++; $display("FAIL timeout_byte%0d: got %h want %h", i, got, exp_q[i]); end
    end
    en16 = 1'b1; len16 = 8; bd = done16;
    send16(16'h5A5A, ok);
    n_vec++;
    if (e16 !== 1'b0) begin n_err++; $display("FAIL timeout_clear: err %b want 0", e16); end
    wait_done16(bd, ok);
  endtask

  task automatic test_reset_mid();
    bit ok; int bl, bt, bd; logic [7:0] got; logic [15:0] w;
    len16 = 20; bt = trig16;
    send16(16'($urandom), ok);
    for (int i = 0; i < 500 && (trig16 - bt) < 2; i++) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({if16.word_ready_out, b16, t16, bo16, fd16, e16} !== {1'b1, 8'h00, 4'b0000}) begin
      n_err++;
      $display("FAIL midreset_outputs: got %b want %b", {if16.word_ready_out, b16, t16, bo16, fd16, e16}, {1'b1, 8'h00, 4'b0000});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    n_vec++;
    if (trig16 - bt !== 2) begin n_err++; $display("FAIL midreset_no_third: got %0d triggers want 2", trig16 - bt); end
    w = 16'($urandom); bl = log16.size(); bd = done16;
    send16(w, ok);
    wait_done16(bd, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL midreset_next_done: frame incomplete"); end
    make_expect({16'h0, w}, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (bl + i < log16.size()) ? log16[bl + i] : 8'hxx;
      n_vec++;
      if (got !== exp_q[i]) begin n_err++; $display("FAIL midreset_byte%0d: got %h want %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit ok; int bl, bd; logic [7:0] got; logic [31:0] w;
    for (int n = 0; n < 6; n++) begin
      w = {16'h0, 16'($urandom)}; len16 = int'($urandom_range(1, 25));
      bl = log16.size(); bd = done16;
      repeat ($urandom_range(0, 4)) @(negedge clk);
      send16(w[15:0], ok);
      wait_done16(bd, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL rand16_done%0d: frame incomplete", n); end
      make_expect(w, 2);
      for (int i = 0; i < exp_q.size(); i++) begin
        got = (bl + i < log16.size()) ? log16[bl + i] : 8'hxx;
        n_vec++;
        if (got !== exp_q[i]) begin n_err++; $display("FAIL rand16_f%0d_b%0d: got %h want %h", n, i, got, exp_q[i]); end
      end
    end
    for (int n = 0; n < 3; n++) begin
      w = $urandom; len32 = int'($urandom_range(1, 25));
      bl = log32.size(); bd = done32;
      send32(w, ok);
      wait_done32(bd, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL rand32_done%0d: frame incomplete", n); end
      make_expect(w, 4);
      for (int i = 0; i < exp_q.size(); i++) begin
        got = (bl + i < log32.size()) ? log32[bl + i] : 8'hxx;
        n_vec++;
        if (got !== exp_q[i]) begin n_err++; $display("FAIL rand32_f%0d_b%0d: got %h want %h", n, i, got, exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wide();
    test_back_to_back();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
